sample_buf_ctrl: RTL and testbench
==================================

# sample_buf_ctrl

Ping-pong buffer controller placed between the UART packet receiver and the downstream scan-point consumer. It takes each frame's metadata and sample words from the receiver and writes them into one of two 256×16 sample banks. It presents completed frames to a single reader in arrival order and recycles banks on release. When no bank is free, it drops whole frames and counts them, so the receiver never stalls.

## Interface
Parameters:
- DATA_W, 16, sample word width
- DEPTH, 256, words per bank (address width 8)
- TIMEOUT_CYC, 50000, inter-word idle limit in clk cycles (used only when timeout is compiled in)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_start  in  1  one-cycle pulse: new frame header, CT, FSA and LSA accepted
- wr_count  in  8  sample count (CT) sampled at wr_start; 0 means 256
- wr_fsa  in  16  start angle, sampled at wr_start
- wr_lsa  in  16  end angle, sampled at wr_start
- wr_valid  in  1  sample word valid
- wr_data  in  DATA_W  sample word
- wr_ready  out  1  controller accepts wr_data this cycle
- frame_avail  out  1  a completed frame is presented to the reader
- frame_ct  out  8  CT of the presented frame
- frame_fsa  out  16  FSA of the presented frame
- frame_lsa  out  16  LSA of the presented frame
- rd_en  in  1  read strobe
- rd_addr  in  8  word index within the presented frame
- rd_data  out  DATA_W  read data, 1-cycle latency
- frame_release  in  1  one-cycle pulse: reader finished with the presented frame
- drop_cnt  out  8  frames dropped; saturates at 255
- err  out  1  one-cycle pulse on frame abort (resync or timeout)

## Operation
- Each bank has its own state: FREE, FILLING, FULL, READING. Each bank has its own metadata registers (ct, fsa, lsa).
- Writer FSM states:
  - W_IDLE: wr_ready=0. On wr_start:
    - If a FREE bank exists, go to W_FILL. Pick bank 0 if both are FREE; otherwise the FREE one. Mark it FILLING, latch the metadata, clear the word counter.
    - Otherwise go to W_DROP and increment drop_cnt (saturating).
  - W_FILL: wr_ready=1. Each wr_valid&wr_ready writes wr_data to bank[idx] and increments idx.
    - After the expected-th word (count, or 256 when count=0), go to W_COMMIT.
  - W_DROP: wr_ready=1. Words are discarded and counted the same way; return to W_IDLE after the last one.
  - W_COMMIT: wr_ready=0. Mark the bank FULL, push its id into the 2-entry order FIFO, return to W_IDLE.
- wr_start while in W_FILL or W_DROP aborts the current frame:
  - A FILLING bank returns to FREE.
  - err pulses.
  - The new frame is handled exactly as wr_start in W_IDLE, in the same cycle.
- Reader side:
  - The head of the order FIFO is the presented bank. Its state becomes READING and frame_avail=1.
  - rd_addr is used only within the presented bank.
  - frame_release while frame_avail=1 sets the bank to FREE and pops the FIFO. frame_release while frame_avail=0 is ignored.
- Frames are always delivered in arrival order. Partial frames are never presented.
- Reads with rd_addr ≥ frame length return the stale RAM contents, not an error.

## Timing
- Reset values: state W_IDLE, both banks FREE, FIFO empty, wr_ready=0, frame_avail=0, frame_ct/fsa/lsa=0, rd_data=0, drop_cnt=0, err=0.
- Reset asserted mid-frame discards all banks and metadata. No err pulse.
- Last word accepted in cycle N → W_COMMIT in N+1 → frame_avail=1 from N+2 (if the FIFO was empty).
- wr_start in cycle N → wr_ready=1 from N+1.
- frame_release in cycle N → frame_avail=0 in N+1; the next FULL bank is presented from N+2.
- rd_en in cycle N → rd_data valid in N+1. This holds even if frame_release is also in cycle N.
- Commit and release in the same cycle both take effect. A bank freed at cycle N is available to a wr_start from N+1.

## Configuration
- SAMPLE_BUF_TIMEOUT_EN defined:
  - In W_FILL/W_DROP, an idle counter resets on every accepted word.
  - Reaching TIMEOUT_CYC aborts the frame: bank returns to FREE, err pulses, state goes to W_IDLE.
- Not defined: no counter. The controller waits indefinitely for words or a new wr_start.

## Structure
- Package sample_buf_pkg holds:
  - bank-state and writer-state enums
  - DEPTH_DEF, DATA_W_DEF
  - the 0-means-256 length helper constant
- Sub-module sample_bank_ram: 256×16 synchronous RAM, one write port and one registered read port, instantiated twice.
- The controller muxes rd_data by presented bank id.

## Test plan
- Single frame: wr_start, count=3, FSA=0x1234, LSA=0x5678, words 0xA001/0xA002/0xA003 → frame_avail 2 cycles after the third word; reads of addr 0..2 return those words; frame_ct=3.
- Two frames back-to-back, no release → both banks FULL; a third wr_start gives drop_cnt=1 and its words are accepted and discarded; after releasing frame 1 the reader sees frame 2 metadata.
- count=0 → exactly 256 words accepted; addr 255 holds the last word; frame_ct=0.
- wr_start after 2 of 5 words → err pulse, bank reused; the new frame's words start at addr 0; the aborted frame is never presented.
- Release and commit in the same cycle → one frame_avail transition sequence with no lost frame; the FIFO order is preserved.
- With SAMPLE_BUF_TIMEOUT_EN and TIMEOUT_CYC=20: stop after 1 word, wait 20 cycles → err pulse, wr_ready=0, bank FREE. Reset low mid-fill → all outputs return to reset values.

Source files
------------

// File: rtl/sample_buf_pkg.sv
// sample_buf_pkg: shared types and constants for the sample ping-pong buffer.
//   bank_state_t : per-bank life cycle (FREE -> FILLING -> FULL -> READING -> FREE)
//   wr_state_t   : writer FSM states
//   DATA_W_DEF, DEPTH_DEF : default word width / words per bank
//   LEN_ZERO_CT, frame_len() : a CT of 0 encodes a full 256-word frame
package sample_buf_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 256;

    // Frame length meant by a CT value of zero
    localparam logic [8:0] LEN_ZERO_CT = 9'd256;

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP,
        W_COMMIT
    } wr_state_t;

    function automatic logic [8:0] frame_len(input logic [7:0] ct);
        return (ct == 8'd0) ? LEN_ZERO_CT : {1'b0, ct};
    endfunction

endpackage

// File: rtl/sample_bank_ram.sv
// sample_bank_ram: one sample bank, DEPTH x DATA_W synchronous RAM.
//   clk, reset       : clock, async active-low reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr, rdata : read port, data registered one cycle after re
module sample_bank_ram
    import sample_buf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is left unreset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_buf_ctrl.sv
// sample_buf_ctrl: ping-pong buffer controller between the packet receiver
// and the scan-point reader. Frames are written into one of two banks,
// presented in arrival order, and dropped (and counted) when no bank is free.
//   Writer : wr_start/wr_count/wr_fsa/wr_lsa header, wr_valid/wr_data/wr_ready words
//   Reader : frame_avail + frame_ct/fsa/lsa, rd_en/rd_addr/rd_data, frame_release
//   Status : drop_cnt (saturating), err (pulse on frame abort)
// Build option: SAMPLE_BUF_TIMEOUT_EN adds an inter-word idle timeout of
// TIMEOUT_CYC cycles that aborts the frame in progress.
module sample_buf_ctrl
    import sample_buf_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_start,
    input  logic [7:0]               wr_count,
    input  logic [15:0]              wr_fsa,
    input  logic [15:0]              wr_lsa,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     frame_avail,
    output logic [7:0]               frame_ct,
    output logic [15:0]              frame_fsa,
    output logic [15:0]              frame_lsa,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     frame_release,
    output logic [7:0]               drop_cnt,
    output logic                     err
);

    localparam int unsigned AW = $clog2(DEPTH);

    wr_state_t   wstate, wstate_nx;
    bank_state_t bank_st [2];
    bank_state_t bank_nx [2];
    logic [7:0]  meta_ct  [2];
    logic [15:0] meta_fsa [2];
    logic [15:0] meta_lsa [2];
    logic        fill_bank;
    logic [8:0]  word_cnt, frame_len_q;
    logic [7:0]  drop_q;
    logic        err_q;

    // Order FIFO: slot 0 is the head (presented bank)
    logic [1:0]  fifo_id, fifo_nx;
    logic [1:0]  fifo_cnt, cnt_nx;
    logic        gap_q;     // forces the one-cycle gap after a release
    logic        head;
    logic        rd_sel_q;

    logic        busy, accept, last_word, timeout;
    logic        abort, abort_fill, commit, release_ok;
    logic        start_fill, new_bank;
    logic [1:0]  free_vec;
    logic [1:0]  ram_we;
    logic [DATA_W-1:0] ram_rdata [2];

    assign busy        = (wstate == W_FILL) || (wstate == W_DROP);
    assign wr_ready    = busy;
    // A header arriving with a word in the same cycle takes priority; the word is not taken
    assign accept      = busy && wr_valid && !wr_start;
    assign last_word   = accept && ((word_cnt + 9'd1) == frame_len_q);
    assign commit      = (wstate == W_COMMIT);
    assign abort       = (busy && wr_start) || timeout;
    assign abort_fill  = abort && (wstate == W_FILL);
    assign head        = fifo_id[0];
    assign frame_avail = (fifo_cnt != 2'd0) && !gap_q;
    assign release_ok  = frame_release && frame_avail;

    // A bank released by the abort in this cycle is already eligible
    assign free_vec[0] = (bank_st[0] == B_FREE) || (abort_fill && !fill_bank);
    assign free_vec[1] = (bank_st[1] == B_FREE) || (abort_fill && fill_bank);
    assign start_fill  = wr_start && (free_vec != 2'b00);
    assign new_bank    = !free_vec[0];

`ifdef SAMPLE_BUF_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!busy || wr_start || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = busy && !wr_start && !accept && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        wstate_nx = wstate;
        ram_we    = '0;
        if (accept && (wstate == W_FILL)) begin
            ram_we[fill_bank] = 1'b1;
        end
        if (wr_start) begin
            wstate_nx = start_fill ? W_FILL : W_DROP;
        end else begin
            case (wstate)
                W_FILL:   if (timeout) wstate_nx = W_IDLE;
                          else if (last_word) wstate_nx = W_COMMIT;
                W_DROP:   if (timeout || last_word) wstate_nx = W_IDLE;
                W_COMMIT: wstate_nx = W_IDLE;
                default:  wstate_nx = W_IDLE;
            endcase
        end
    end

    // Later rules win: a bank can be freed and re-claimed in the same cycle
    always_comb begin
        bank_nx = bank_st;
        for (int unsigned i = 0; i < 2; i++) begin
            if (frame_avail && (head == 1'(i)) && (bank_st[i] == B_FULL)) bank_nx[i] = B_READING;
            if (release_ok && (head == 1'(i)))                           bank_nx[i] = B_FREE;
            if (abort_fill && (fill_bank == 1'(i)))                       bank_nx[i] = B_FREE;
            if (commit && (fill_bank == 1'(i)))                           bank_nx[i] = B_FULL;
            if (start_fill && (new_bank == 1'(i)))                        bank_nx[i] = B_FILLING;
        end
    end

    // Pop before push so a same-cycle commit lands behind the remaining entry
    always_comb begin
        fifo_nx = fifo_id;
        cnt_nx  = fifo_cnt;
        if (release_ok) begin
            fifo_nx[0] = fifo_id[1];
            cnt_nx     = cnt_nx - 2'd1;
        end
        if (commit) begin
            fifo_nx[cnt_nx[0]] = fill_bank;
            cnt_nx             = cnt_nx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstate      <= W_IDLE;
            fill_bank   <= 1'b0;
            word_cnt    <= '0;
            frame_len_q <= '0;
            drop_q      <= '0;
            err_q       <= 1'b0;
            bank_st     <= '{B_FREE, B_FREE};
            meta_ct     <= '{'0, '0};
            meta_fsa    <= '{'0, '0};
            meta_lsa    <= '{'0, '0};
            fifo_id     <= '0;
            fifo_cnt    <= '0;
            gap_q       <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            wstate   <= wstate_nx;
            err_q    <= abort;
            bank_st  <= bank_nx;
            fifo_id  <= fifo_nx;
            fifo_cnt <= cnt_nx;
            gap_q    <= release_ok;
            if (rd_en) begin
                rd_sel_q <= head;
            end
            if (wr_start) begin
                word_cnt    <= '0;
                frame_len_q <= frame_len(wr_count);
                if (start_fill) begin
                    fill_bank          <= new_bank;
                    meta_ct[new_bank]  <= wr_count;
                    meta_fsa[new_bank] <= wr_fsa;
                    meta_lsa[new_bank] <= wr_lsa;
                end else if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end else if (accept) begin
                word_cnt <= word_cnt + 9'd1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sample_bank_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (ram_we[g]),
            .waddr (word_cnt[AW-1:0]),
            .wdata (wr_data),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (ram_rdata[g])
        );
    end

    always_comb begin
        rd_data   = ram_rdata[rd_sel_q];
        frame_ct  = '0;
        frame_fsa = '0;
        frame_lsa = '0;
        if (frame_avail) begin
            frame_ct  = meta_ct[head];
            frame_fsa = meta_fsa[head];
            frame_lsa = meta_lsa[head];
        end
    end

    assign drop_cnt = drop_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// tb_sample_buf_ctrl: scoreboard bench for sample_buf_ctrl. Frames that the
// controller is expected to keep are pushed (metadata + words) when written
// and popped when the reader is presented them. Timeout scenario runs only
// when SAMPLE_BUF_TIMEOUT_EN is defined (bench uses TIMEOUT_CYC=20).
module tb_sample_buf_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_start, wr_valid, wr_ready;
    logic [7:0]  wr_count;
    logic [15:0] wr_fsa, wr_lsa, wr_data;
    logic        frame_avail;
    logic [7:0]  frame_ct;
    logic [15:0] frame_fsa, frame_lsa;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_release;
    logic [7:0]  drop_cnt;
    logic        err;

    typedef struct {
        logic [7:0]  ct;
        logic [15:0] fsa;
        logic [15:0] lsa;
        int unsigned len;
    } frame_t;

    frame_t      exp_frames[$];
    logic [15:0] exp_words[$];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    sample_buf_ctrl #(
        .DATA_W      (16),
        .DEPTH       (256),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_start      (wr_start),
        .wr_count      (wr_count),
        .wr_fsa        (wr_fsa),
        .wr_lsa        (wr_lsa),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .frame_avail   (frame_avail),
        .frame_ct      (frame_ct),
        .frame_fsa     (frame_fsa),
        .frame_lsa     (frame_lsa),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_release (frame_release),
        .drop_cnt      (drop_cnt),
        .err           (err)
    );

    // Header, then nwords back-to-back words; queued in the scoreboard if kept
    task automatic send_frame(input logic [7:0] ct, input logic [15:0] fsa, input logic [15:0] lsa,
                              input logic [15:0] base, input int unsigned nwords, input bit store,
                              output logic err_seen);
        frame_t f;
        @(negedge clk);
        wr_start = 1'b1; wr_count = ct; wr_fsa = fsa; wr_lsa = lsa; wr_valid = 1'b0;
        @(negedge clk);
        wr_start = 1'b0;
        err_seen = err;
        compared++;
        if (wr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL start_ready: got %b expected 1", wr_ready);
        end
        for (int unsigned i = 0; i < nwords; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 16'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (store) begin
            f.ct = ct; f.fsa = fsa; f.lsa = lsa;
            f.len = (ct == 8'd0) ? 256 : int'(ct);
            exp_frames.push_back(f);
            for (int unsigned i = 0; i < nwords; i++) exp_words.push_back(base + 16'(i));
        end
    endtask

    // Wait for a presented frame, compare metadata and every word (no release)
    task automatic read_body();
        frame_t      f;
        logic [15:0] w;
        int unsigned waited = 0;
        while (frame_avail !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (frame_avail !== 1'b1) begin
            mismatched++;
            $display("FAIL avail_wait: got %b expected 1 within 50 cycles", frame_avail);
        end
        compared++;
        if (exp_frames.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty: got 0 queued frames expected >= 1");
            return;
        end
        f = exp_frames.pop_front();
        compared++;
        if (frame_ct !== f.ct) begin
            mismatched++;
            $display("FAIL frame_ct: got %h expected %h", frame_ct, f.ct);
        end
        compared++;
        if (frame_fsa !== f.fsa || frame_lsa !== f.lsa) begin
            mismatched++;
            $display("FAIL frame_angles: got %h/%h expected %h/%h", frame_fsa, frame_lsa, f.fsa, f.lsa);
        end
        for (int unsigned a = 0; a < f.len; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            @(negedge clk);
            w = exp_words.pop_front();
            compared++;
            if (rd_data !== w) begin
                mismatched++;
                $display("FAIL rd_data[%0d]: got %h expected %h", a, rd_data, w);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
        compared++;
        if (frame_avail !== 1'b0) begin
            mismatched++;
            $display("FAIL release_avail: got %b expected 0", frame_avail);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        compared++;
        if ({wr_ready, frame_avail, err} !== 3'b000 || frame_ct !== 8'h00 || frame_fsa !== 16'h0000 ||
            frame_lsa !== 16'h0000 || rd_data !== 16'h0000 || drop_cnt !== 8'h00) begin
            mismatched++;
            $display("FAIL %s: got rdy=%b av=%b err=%b ct=%h fsa=%h lsa=%h rd=%h drop=%h expected all zero",
                     tag, wr_ready, frame_avail, err, frame_ct, frame_fsa, frame_lsa, rd_data, drop_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_start = 1'b0; wr_count = '0; wr_fsa = '0; wr_lsa = '0; wr_valid = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; frame_release = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_in");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_out");
    endtask

    task automatic test_single_frame();
        logic e;
        send_frame(8'd3, 16'h1234, 16'h5678, 16'hA001, 3, 1'b1, e);
        compared++;
        if (e !== 1'b0) begin
            mismatched++;
            $display("FAIL single_err: got %b expected 0", e);
        end
        compared++;
        if (frame_avail !== 1'b0) begin
            mismatched++;
            $display("FAIL single_commit_cycle: got avail %b expected 0", frame_avail);
        end
        @(negedge clk);
        compared++;
        if (frame_avail !== 1'b1) begin
            mismatched++;
            $display("FAIL single_latency: got avail %b expected 1", frame_avail);
        end
        read_body();
        release_frame();
    endtask

    task automatic test_back_to_back();
        logic e;
        send_frame(8'd4, 16'h1111, 16'h1112, 16'hB100, 4, 1'b1, e);
        send_frame(8'd2, 16'h2222, 16'h2223, 16'hB200, 2, 1'b1, e);
        send_frame(8'd3, 16'h3333, 16'h3334, 16'hB300, 3, 1'b0, e);
        compared++;
        if (drop_cnt !== 8'd1) begin
            mismatched++;
            $display("FAIL drop_cnt: got %0d expected 1", drop_cnt);
        end
        compared++;
        if (wr_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL drop_done_ready: got %b expected 0", wr_ready);
        end
        read_body();
        release_frame();
        @(negedge clk);
        compared++;
        if (frame_avail !== 1'b1 || frame_fsa !== 16'h2222) begin
            mismatched++;
            $display("FAIL next_present: got avail %b fsa %h expected 1 2222", frame_avail, frame_fsa);
        end
        read_body();
        release_frame();
    endtask

    task automatic test_count_zero();
        logic e;
        send_frame(8'd0, 16'h0A0A, 16'h0B0B, 16'hC000, 256, 1'b1, e);
        read_body();
        release_frame();
    endtask

    task automatic test_abort();
        logic e;
        send_frame(8'd5, 16'h4444, 16'h4445, 16'hD000, 2, 1'b0, e);
        send_frame(8'd2, 16'h5555, 16'h5556, 16'hE000, 2, 1'b1, e);
        compared++;
        if (e !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_err: got %b expected 1", e);
        end
        send_frame(8'd1, 16'h6666, 16'h6667, 16'hF000, 1, 1'b1, e);
        compared++;
        if (drop_cnt !== 8'd1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_reuse: got drop %0d err %b expected 1 0", drop_cnt, err);
        end
        read_body();
        release_frame();
        read_body();
        release_frame();
        repeat (4) @(negedge clk);
        compared++;
        if (frame_avail !== 1'b0) begin
            mismatched++;
            $display("FAIL aborted_presented: got avail %b expected 0", frame_avail);
        end
    endtask

    task automatic test_release_commit();
        logic e;
        send_frame(8'd2, 16'h7070, 16'h7071, 16'h1100, 2, 1'b1, e);
        read_body();
        send_frame(8'd3, 16'h8080, 16'h8081, 16'h1200, 3, 1'b1, e);
        // Now in the commit cycle of the second frame
        release_frame();
        @(negedge clk);
        compared++;
        if (frame_avail !== 1'b1 || frame_fsa !== 16'h8080) begin
            mismatched++;
            $display("FAIL relcommit_next: got avail %b fsa %h expected 1 8080", frame_avail, frame_fsa);
        end
        read_body();
        release_frame();
    endtask

`ifdef SAMPLE_BUF_TIMEOUT_EN
    task automatic test_timeout();
        logic e;
        send_frame(8'd5, 16'h9090, 16'h9091, 16'h3300, 1, 1'b0, e);
        repeat (19) @(negedge clk);
        compared++;
        if (err !== 1'b0 || wr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_early: got err %b ready %b expected 0 1", err, wr_ready);
        end
        @(negedge clk);
        compared++;
        if (err !== 1'b1 || wr_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_fire: got err %b ready %b expected 1 0", err, wr_ready);
        end
        @(negedge clk);
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_pulse: got err %b expected 0", err);
        end
        send_frame(8'd1, 16'h9191, 16'h9192, 16'h3400, 1, 1'b1, e);
        send_frame(8'd1, 16'h9292, 16'h9293, 16'h3500, 1, 1'b1, e);
        compared++;
        if (drop_cnt !== 8'd1) begin
            mismatched++;
            $display("FAIL timeout_bank_free: got drop %0d expected 1", drop_cnt);
        end
        read_body();
        release_frame();
        read_body();
        release_frame();
    endtask
`endif

    task automatic test_reset_mid_fill();
        logic e;
        send_frame(8'd2, 16'hAAAA, 16'hAAAB, 16'h5500, 2, 1'b0, e);
        send_frame(8'd4, 16'hBBBB, 16'hBBBC, 16'h5600, 2, 1'b0, e);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid_after");
        send_frame(8'd1, 16'hCCCC, 16'hCCCD, 16'h5700, 1, 1'b1, e);
        send_frame(8'd1, 16'hDDDD, 16'hDDDE, 16'h5800, 1, 1'b1, e);
        compared++;
        if (drop_cnt !== 8'd0 || e !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_banks_free: got drop %0d err %b expected 0 0", drop_cnt, e);
        end
        read_body();
        release_frame();
        read_body();
        release_frame();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_count_zero();
        test_abort();
        test_release_commit();
`ifdef SAMPLE_BUF_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
